aes_round_sequencer: RTL and testbench

Control FSM that runs one AES block encryption by sequencing the KeyExpansion, AddRoundKey, SubBytes, ShiftRows and MixColumns units of the AES_Encrypt datapath. It exposes an HLS-style ap_ctrl_hs block handshake upward and drives per-unit start/done handshakes or one-cycle strobes downward. It also supplies the round index used for round-key selection, and skips key expansion when the cached schedule is still valid.

---
 rtl/aes_round_sequencer_if.sv | 34 +++
 rtl/aes_round_sequencer.sv | 156 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Block-level bundle for aes_round_sequencer: ap_ctrl_hs host handshake,
// per-unit start/done handshakes, datapath strobes, round index and status.
interface aes_round_sequencer_if;
  logic        ap_start;
  logic        key_new;
  logic        ap_done;
  logic        ap_ready;
  logic        ap_idle;
  logic        ke_start;
  logic        ke_done;
  logic        ark_start;
  logic        ark_done;
  logic        sb_start;
  logic        sb_done;
  logic        sr_en;
  logic        mc_en;
  logic [3:0]  round;
  logic        protocol_err;
  logic [15:0] perf_cycles;

  // Host and datapath units: drive requests and dones, observe the sequencer.
  modport master (
    output ap_start, key_new, ke_done, ark_done, sb_done,
    input  ap_done, ap_ready, ap_idle, ke_start, ark_start, sb_start,
           sr_en, mc_en, round, protocol_err, perf_cycles
  );

  // The sequencer itself.
  modport slave (
    input  ap_start, key_new, ke_done, ark_done, sb_done,
    output ap_done, ap_ready, ap_idle, ke_start, ark_start, sb_start,
           sr_en, mc_en, round, protocol_err, perf_cycles
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES encryption round sequencer: drives KeyExpansion/AddRoundKey/SubBytes/
// ShiftRows/MixColumns per round. Optional cycle counter under AES_SEQ_PERF_EN.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  aes_round_sequencer_if.slave  bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYEXP, S_ARK0, S_SB, S_SR, S_MC, S_ARK, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       key_loaded_q, key_loaded_d;
  logic       perr_q, perr_d;
  logic       accept;
  logic       proto_viol;

  logic ap_done_q, ap_idle_q;
  logic ke_start_q, ark_start_q, sb_start_q, sr_en_q, mc_en_q;

  // A done without its start asserted is flagged and never advances the FSM.
  assign proto_viol = (bus.ke_done  & ~ke_start_q)
                    | (bus.ark_done & ~ark_start_q)
                    | (bus.sb_done  & ~sb_start_q);

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    key_loaded_d = key_loaded_q;
    perr_d       = perr_q;
    accept       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          accept  = 1'b1;
          round_d = 4'd0;
          state_d = (bus.key_new || !key_loaded_q) ? S_KEYEXP : S_ARK0;
        end
      end
      S_KEYEXP: begin
        if (bus.ke_done) begin
          state_d      = S_ARK0;
          key_loaded_d = 1'b1;
        end
      end
      S_ARK0: begin
        if (bus.ark_done) begin
          state_d = S_SB;
          round_d = 4'd1;
        end
      end
      S_SB: begin
        if (bus.sb_done) state_d = S_SR;
      end
      S_SR: begin
        state_d = (round_q < LAST_ROUND) ? S_MC : S_ARK;
      end
      S_MC: begin
        state_d = S_ARK;
      end
      S_ARK: begin
        if (bus.ark_done) begin
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SB;
            round_d = round_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (accept)     perr_d = 1'b0;
    if (proto_viol) perr_d = 1'b1;
  end

  // Outputs are registered decodes of the next state, so they line up with state_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      round_q      <= 4'd0;
      key_loaded_q <= 1'b0;
      perr_q       <= 1'b0;
      ap_done_q    <= 1'b0;
      ap_idle_q    <= 1'b1;
      ke_start_q   <= 1'b0;
      ark_start_q  <= 1'b0;
      sb_start_q   <= 1'b0;
      sr_en_q      <= 1'b0;
      mc_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      key_loaded_q <= key_loaded_d;
      perr_q       <= perr_d;
      ap_done_q    <= (state_d == S_DONE);
      ap_idle_q    <= (state_d == S_IDLE);
      ke_start_q   <= (state_d == S_KEYEXP);
      ark_start_q  <= (state_d == S_ARK0) || (state_d == S_ARK);
      sb_start_q   <= (state_d == S_SB);
      sr_en_q      <= (state_d == S_SR);
      mc_en_q      <= (state_d == S_MC);
    end
  end

  assign bus.ap_done      = ap_done_q;
  assign bus.ap_ready     = ap_done_q;
  assign bus.ap_idle      = ap_idle_q;
  assign bus.ke_start     = ke_start_q;
  assign bus.ark_start    = ark_start_q;
  assign bus.sb_start     = sb_start_q;
  assign bus.sr_en        = sr_en_q;
  assign bus.mc_en        = mc_en_q;
  assign bus.round        = round_q;
  assign bus.protocol_err = perr_q;

`ifdef AES_SEQ_PERF_EN
  logic [15:0] perf_cnt_q;
  logic [15:0] perf_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counter covers the accept cycle through the DONE cycle inclusive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt_q <= 16'd0;
      perf_q     <= 16'd0;
    end else begin
      if (accept) begin
        perf_cnt_q <= 16'd1;
      end else if (state_q != S_IDLE) begin
        perf_cnt_q <= sat_inc(perf_cnt_q);
      end
      if (state_q == S_DONE) perf_q <= sat_inc(perf_cnt_q);
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: per-cycle comparison against a
// schedule model, plus literal latency/episode/status expectations.
module tb_aes_round_sequencer;
  localparam int NR = 10;

  localparam logic [2:0] U_IDLE = 3'd0, U_KE = 3'd1, U_ARK = 3'd2, U_SB = 3'd3,
                         U_SR = 3'd4, U_MC = 3'd5, U_DONE = 3'd6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  aes_round_sequencer_if bus();
  aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Unit responders: done rises once the start has been high L cycles.
  int   l_ke = 2, l_ark = 2, l_sb = 2;
  int   ke_cnt = 0, ark_cnt = 0, sb_cnt = 0;
  logic ke_resp = 1'b0, ark_resp = 1'b0, sb_resp = 1'b0, inj_ark = 1'b0;
  assign bus.ke_done  = ke_resp;
  assign bus.ark_done = ark_resp | inj_ark;
  assign bus.sb_done  = sb_resp;

  always @(posedge clock) begin
    #1;
    ke_cnt   = bus.ke_start  ? ke_cnt + 1  : 0;
    ark_cnt  = bus.ark_start ? ark_cnt + 1 : 0;
    sb_cnt   = bus.sb_start  ? sb_cnt + 1  : 0;
    ke_resp  = bus.ke_start  && (ke_cnt  >= l_ke);
    ark_resp = bus.ark_start && (ark_cnt >= l_ark);
    sb_resp  = bus.sb_start  && (sb_cnt  >= l_sb);
  end

  // Model: queue of expected per-cycle activity for the running encryption.
  typedef struct packed {
    logic [2:0] unit;
    logic [3:0] rnd;
  } step_t;

  step_t       q[$];
  logic [3:0]  idle_round = 4'd0;
  logic        exp_perr   = 1'b0;
  logic [15:0] exp_perf   = 16'd0;
  logic [15:0] pend_perf  = 16'd0;
  bit          model_key  = 1'b0;
  bit          checking   = 1'b0;

  function automatic logic [28:0] pack_exp(input logic [2:0] u, input logic [3:0] r);
    return {u == U_DONE, u == U_DONE, u == U_IDLE, u == U_KE, u == U_ARK,
            u == U_SB, u == U_SR, u == U_MC, r, exp_perr, exp_perf};
  endfunction

  function automatic logic [28:0] pack_act();
    return {bus.ap_done, bus.ap_ready, bus.ap_idle, bus.ke_start, bus.ark_start,
            bus.sb_start, bus.sr_en, bus.mc_en, bus.round, bus.protocol_err,
            bus.perf_cycles};
  endfunction

  always @(negedge clock) begin
    step_t       s;
    logic [28:0] e;
    logic [28:0] a;
    if (reset_n && checking) begin
      if (q.size() > 0) s = q.pop_front();
      else              s = '{unit: U_IDLE, rnd: idle_round};
      e = pack_exp(s.unit, s.rnd);
      a = pack_act();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, a, e);
      end
      if (s.unit == U_DONE) begin
        idle_round = s.rnd;
        exp_perf   = pend_perf;
      end
    end
  end

  // Episode counters: rising edges of ke/ark/sb starts and sr/mc strobes.
  int         ep[5];
  logic [4:0] prev_st = 5'd0;
  always @(negedge clock) begin
    logic [4:0] cur;
    cur = {bus.ke_start, bus.ark_start, bus.sb_start, bus.sr_en, bus.mc_en};
    for (int i = 0; i < 5; i++) if (cur[i] && !prev_st[i]) ep[i]++;
    prev_st = cur;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push(input logic [2:0] u, input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) q.push_back('{unit: u, rnd: r});
  endtask

  task automatic start_enc(input bit kn, input int lsb);
    bit do_ke;
    l_sb = lsb;
    for (int i = 0; i < 5; i++) ep[i] = 0;
    @(negedge clock);
    bus.key_new  = kn;
    bus.ap_start = 1'b1;
    @(posedge clock);
    #1;
    bus.ap_start = 1'b0;
    bus.key_new  = 1'b0;
    do_ke     = kn || !model_key;
    model_key = 1'b1;
    exp_perr  = 1'b0;
    if (do_ke) push(U_KE, 4'd0, l_ke);
    push(U_ARK, 4'd0, l_ark);
    for (int r = 1; r <= NR; r++) begin
      push(U_SB, 4'(r), lsb);
      push(U_SR, 4'(r), 1);
      if (r < NR) push(U_MC, 4'(r), 1);
      push(U_ARK, 4'(r), l_ark);
    end
    push(U_DONE, 4'(NR), 1);
`ifdef AES_SEQ_PERF_EN
    pend_perf = 16'(q.size() + 1);
`else
    pend_perf = 16'd0;
`endif
  endtask

  task automatic wait_done(input string nm, input int req_cycle);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 1000) begin
      @(negedge clock);
      n++;
      seen = bus.ap_done;
    end
    chk({nm, "_done_cycle"}, seen ? n : -1, req_cycle);
  endtask

  task automatic chk_perf(input string nm, input int req_perf);
    @(negedge clock);
`ifdef AES_SEQ_PERF_EN
    chk(nm, int'(bus.perf_cycles), req_perf);
`else
    chk(nm, int'(bus.perf_cycles), 0);
`endif
  endtask

  initial begin
    int n;
    bus.ap_start = 1'b0;
    bus.key_new  = 1'b0;

    #12;
    chk("reset_outputs", int'(pack_act()), int'({3'b001, 26'd0}));

    @(negedge clock);
    reset_n  = 1'b1;
    checking = 1'b1;
    for (int i = 0; i < 5; i++) ep[i] = 0;
    repeat (10) @(negedge clock);
    chk("idle_strobes", ep[0] + ep[1] + ep[2] + ep[3] + ep[4], 0);

    // First encryption: key not yet loaded, so expansion runs.
    start_enc(1'b0, 2);
    wait_done("first", 64);
    chk("first_ke_eps",  ep[4], 1);
    chk("first_ark_eps", ep[3], 11);
    chk("first_sb_eps",  ep[2], 10);
    chk("first_sr_eps",  ep[1], 10);
    chk("first_mc_eps",  ep[0], 9);

    start_enc(1'b0, 2);
    wait_done("cached", 62);
    chk("cached_ke_eps", ep[4], 0);
    chk_perf("cached_perf", 63);

    start_enc(1'b1, 2);
    wait_done("newkey", 64);
    chk("newkey_ke_eps", ep[4], 1);
    chk_perf("newkey_perf", 65);

    start_enc(1'b0, 6);
    wait_done("slow_sb", 102);
    chk("slow_sb_eps", ep[2], 10);
    chk_perf("slow_perf", 103);

    // Reset in round 5 SubBytes abandons the run and forgets the key.
    start_enc(1'b0, 2);
    n = 0;
    while (!(bus.round == 4'd5 && bus.sb_start) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("reach_round5_sb", (n < 200) ? 1 : 0, 1);
    #2;
    reset_n = 1'b0;
    q.delete();
    idle_round = 4'd0;
    exp_perr   = 1'b0;
    exp_perf   = 16'd0;
    model_key  = 1'b0;
    #1;
    chk("midreset_outputs", int'(pack_act()), int'({3'b001, 26'd0}));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_enc(1'b0, 2);
    wait_done("after_reset", 64);
    chk("after_reset_ke_eps", ep[4], 1);

    // Stray ark_done while idle raises a sticky error cleared by the next accept.
    @(negedge clock);
    @(negedge clock);
    inj_ark = 1'b1;
    @(posedge clock);
    #1;
    inj_ark  = 1'b0;
    exp_perr = 1'b1;
    @(negedge clock);
    chk("perr_set", int'(bus.protocol_err), 1);
    repeat (3) @(negedge clock);
    chk("perr_sticky", int'(bus.protocol_err), 1);
    start_enc(1'b0, 2);
    wait_done("perr_run", 62);
    chk("perr_cleared", int'(bus.protocol_err), 0);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
